// File: rtl/sram_dot_engine.sv
// Streams two vectors from a dual-port SRAM and accumulates their signed fixed-point dot product.
// Optional build macro DOT_SAT_EN: saturate the result to BITS instead of keeping only the low bits.
module sram_dot_engine #(
  parameter int BITS       = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int FRAC_BITS  = 0,
  parameter int ACC_BITS   = 80
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [BITS-1:0]       result,
  output logic                  CENA,
  output logic                  CENB,
  output logic                  WENA,
  output logic                  WENB,
  output logic [ADDR_WIDTH-1:0] AA,
  output logic [ADDR_WIDTH-1:0] AB,
  output logic [BITS-1:0]       DA,
  output logic [BITS-1:0]       DB,
  input  logic [BITS-1:0]       QA,
  input  logic [BITS-1:0]       QB
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_READ       = 3'd1;
  localparam logic [2:0] S_DRAIN      = 3'd2;
  localparam logic [2:0] S_ACCUM_LAST = 3'd3;
  localparam logic [2:0] S_FINISH     = 3'd4;

  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;

`ifdef DOT_SAT_EN
  localparam logic signed [ACC_BITS-1:0] SAT_MAX = {{(ACC_BITS-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = {{(ACC_BITS-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
`endif

  logic [2:0]                  state_q, state_d;
  logic [ADDR_WIDTH:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]         len_q, len_d;
  logic [ADDR_WIDTH-1:0]       base_a_q, base_a_d;
  logic [ADDR_WIDTH-1:0]       base_b_q, base_b_d;
  logic signed [ACC_BITS-1:0]  acc_q, acc_d;
  logic                        vld_p1_q, vld_p1_d;
  logic [BITS-1:0]             result_q, result_d;
  logic                        done_q, done_d;

  logic signed [BITS-1:0]      qa_s, qb_s;
  logic signed [2*BITS-1:0]    prod_p1;
  logic signed [ACC_BITS-1:0]  prod_ext_p1;

  // Q-format realignment, then reduction to the output word.
  function automatic logic [BITS-1:0] reduce_acc(input logic signed [ACC_BITS-1:0] a);
    logic signed [ACC_BITS-1:0] r;
    r = a >>> FRAC_BITS;
`ifdef DOT_SAT_EN
    if (r > SAT_MAX)      reduce_acc = SAT_MAX[BITS-1:0];
    else if (r < SAT_MIN) reduce_acc = SAT_MIN[BITS-1:0];
    else                  reduce_acc = r[BITS-1:0];
`else
    reduce_acc = r[BITS-1:0];
`endif
  endfunction

  // Stage p1: SRAM data arrives the cycle after the CEN-low cycle
  assign qa_s        = QA;
  assign qb_s        = QB;
  assign prod_p1     = (2*BITS)'(qa_s) * (2*BITS)'(qb_s);
  assign prod_ext_p1 = ACC_BITS'(prod_p1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    vld_p1_d = (state_q == S_READ);

    if (vld_p1_q) acc_d = acc_q + prod_ext_p1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_a_d = base_a;
          base_b_d = base_b;
          len_d    = len;
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = (len == CNT_ZERO) ? S_FINISH : S_READ;
        end
      end
      S_READ: begin
        if (cnt_q + CNT_ONE == len_q) state_d = S_DRAIN;
        else                          cnt_d   = cnt_q + CNT_ONE;
      end
      S_DRAIN:      state_d = S_ACCUM_LAST;
      // The final accumulate has landed; register the result as the engine returns to IDLE.
      S_ACCUM_LAST: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        result_d = reduce_acc(acc_q);
      end
      S_FINISH: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        result_d = reduce_acc(acc_q);
      end
      default:      state_d = S_IDLE;
    endcase
  end

  // Stage p2: accumulator and control state update
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      acc_q    <= '0;
      vld_p1_q <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      acc_q    <= acc_d;
      vld_p1_q <= vld_p1_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign CENA   = (state_q != S_READ);
  assign CENB   = (state_q != S_READ);
  assign AA     = (state_q == S_READ) ? base_a_q + cnt_q[ADDR_WIDTH-1:0] : '0;
  assign AB     = (state_q == S_READ) ? base_b_q + cnt_q[ADDR_WIDTH-1:0] : '0;
  assign WENA   = 1'b1;
  assign WENB   = 1'b1;
  assign DA     = '0;
  assign DB     = '0;

endmodule

// File: tb/tb_sram_dot_engine.sv
// Directed bench for sram_dot_engine: table of runs against a dual-port SRAM model, plus reset and Q-format sequences.
module tb_sram_dot_engine;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        start, start_f;
  logic [12:0] base_a, base_b;
  logic [13:0] len;

  logic        busy, done, CENA, CENB, WENA, WENB;
  logic [31:0] result, DA, DB;
  logic [12:0] AA, AB;
  logic [31:0] qa, qb;

  logic        busy_f, done_f, CENA_f, CENB_f, WENA_f, WENB_f;
  logic [31:0] result_f, DA_f, DB_f;
  logic [12:0] AA_f, AB_f;
  logic [31:0] qa_f, qb_f;

  logic [31:0] mem [0:8191];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  sram_dot_engine #(.BITS(32), .ADDR_WIDTH(13), .FRAC_BITS(0), .ACC_BITS(80)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .base_a(base_a), .base_b(base_b), .len(len),
    .busy(busy), .done(done), .result(result), .CENA(CENA), .CENB(CENB), .WENA(WENA), .WENB(WENB),
    .AA(AA), .AB(AB), .DA(DA), .DB(DB), .QA(qa), .QB(qb));

  sram_dot_engine #(.BITS(32), .ADDR_WIDTH(13), .FRAC_BITS(16), .ACC_BITS(80)) dut_f (
    .CLK(CLK), .rst_n(rst_n), .start(start_f), .base_a(base_a), .base_b(base_b), .len(len),
    .busy(busy_f), .done(done_f), .result(result_f), .CENA(CENA_f), .CENB(CENB_f), .WENA(WENA_f),
    .WENB(WENB_f), .AA(AA_f), .AB(AB_f), .DA(DA_f), .DB(DB_f), .QA(qa_f), .QB(qb_f));

  // Registered-read SRAM ports, one pair per engine, sharing one array
  always @(posedge CLK) begin
    if (!CENA)   qa   <= mem[AA];
    if (!CENB)   qb   <= mem[AB];
    if (!CENA_f) qa_f <= mem[AA_f];
    if (!CENB_f) qb_f <= mem[AB_f];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [12:0] ba, input logic [12:0] bb, input logic [13:0] n,
                        input bit poke, output logic [31:0] res, output int lat,
                        output int cen_cnt, output int addr_err, output int busy_cnt,
                        output logic busy_at_done);
    logic [12:0] ea, eb;
    @(negedge CLK);
    base_a = ba; base_b = bb; len = n; start = 1'b1;
    res = '0; lat = -1; cen_cnt = 0; addr_err = 0; busy_cnt = 0; busy_at_done = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (k == 0) begin
        start = 1'b0; base_a = 13'h1555; base_b = 13'h0AAA; len = 14'd7;
      end
      if (poke && k == 2) start = 1'b1;
      if (poke && k == 3) start = 1'b0;
      ea = ba + 13'(k);
      eb = bb + 13'(k);
      if (CENA !== CENB) addr_err++;
      if (!CENA) begin
        cen_cnt++;
        if (AA !== ea || AB !== eb) addr_err++;
      end
      if (done) begin
        lat = k; res = result; busy_at_done = busy;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  typedef struct {
    string       name;
    logic [12:0] ba;
    logic [12:0] bb;
    logic [13:0] n;
    bit          poke;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] res;
    int lat, cen_cnt, addr_err, busy_cnt;
    logic busy_at_done;
    bit saw_done;

    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
    mem[100] = 32'd5; mem[101] = 32'd6; mem[102] = 32'd7; mem[103] = 32'd8;
    mem[200] = 32'd3; mem[201] = 32'd4; mem[202] = 32'd5; mem[203] = 32'd6;
    mem[300] = 32'h7FFFFFFF; mem[301] = 32'h7FFFFFFF;
    mem[400] = 32'hFFFFFFFD; mem[401] = 32'd7;
    mem[500] = 32'h00018000; mem[501] = 32'h00020000;
    mem[8190] = 32'd10; mem[8191] = 32'hFFFFFFEC;

    vecs[0] = '{"dot4",      13'd0,    13'd100, 14'd4, 1'b0, 32'd70,       6};
    vecs[1] = '{"neg1",      13'd400,  13'd401, 14'd1, 1'b0, 32'hFFFFFFEB, 3};
`ifdef DOT_SAT_EN
    vecs[2] = '{"ovf",       13'd300,  13'd300, 14'd2, 1'b0, 32'h7FFFFFFF, 4};
`else
    vecs[2] = '{"ovf",       13'd300,  13'd300, 14'd2, 1'b0, 32'h00000002, 4};
`endif
    vecs[3] = '{"wrap_poke", 13'd8190, 13'd200, 14'd4, 1'b1, 32'hFFFFFFDF, 6};
    vecs[4] = '{"len0",      13'd0,    13'd100, 14'd0, 1'b0, 32'd0,        1};
    vecs[5] = '{"b2b",       13'd0,    13'd100, 14'd4, 1'b0, 32'd70,       6};

    rst_n = 1'b0; start = 1'b0; start_f = 1'b0;
    base_a = '0; base_b = '0; len = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cen", {30'd0, CENA, CENB}, 32'd3);
    chk("rst_addr", {6'd0, AA, AB}, 32'd0);
    chk("rst_wen_d", {30'd0, WENA, WENB} | DA | DB, 32'd3);
    @(negedge CLK);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_op(vecs[v].ba, vecs[v].bb, vecs[v].n, vecs[v].poke,
             res, lat, cen_cnt, addr_err, busy_cnt, busy_at_done);
      chk({vecs[v].name, "_result"}, res, vecs[v].exp_res);
      chk({vecs[v].name, "_latency"}, 32'(lat), 32'(vecs[v].exp_lat));
      chk({vecs[v].name, "_cen_cycles"}, 32'(cen_cnt), 32'(vecs[v].n));
      chk({vecs[v].name, "_addr_err"}, 32'(addr_err), 32'd0);
      chk({vecs[v].name, "_busy_cycles"}, 32'(busy_cnt), 32'(vecs[v].exp_lat));
      chk({vecs[v].name, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    end

    // Asynchronous reset while index 2 is being read
    @(negedge CLK);
    base_a = 13'd0; base_b = 13'd100; len = 14'd4; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("pre_rst_addr", 32'(AA), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cen", {30'd0, CENA, CENB}, 32'd3);
    chk("midrst_result", result, 32'd0);
    chk("midrst_addr", {6'd0, AA, AB}, 32'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", 32'(saw_done), 32'd0);
    run_op(13'd0, 13'd100, 14'd4, 1'b0, res, lat, cen_cnt, addr_err, busy_cnt, busy_at_done);
    chk("post_rst_result", res, 32'd70);
    chk("post_rst_latency", 32'(lat), 32'd6);

    // Q16.16 operands on the FRAC_BITS=16 instance
    @(negedge CLK);
    base_a = 13'd500; base_b = 13'd501; len = 14'd1; start_f = 1'b1;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      if (k == 0) start_f = 1'b0;
      if (done_f) begin
        lat = k;
        break;
      end
    end
    chk("frac16_result", result_f, 32'h00030000);
    chk("frac16_latency", 32'(lat), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
